// File: rtl/trace_checker.sv
// Compares each retired instruction from the CPU commit port against a golden record
// read from an expected-trace ROM; reports done, or the first mismatch with its cause.
module trace_checker #(
  parameter int unsigned ADDR_W      = 10,
  parameter int unsigned NUM_RECORDS = 1024,
  parameter int unsigned TIMEOUT     = 4096,
  parameter int unsigned TO_W        = 16
) (
  input  logic              clk_in,
  input  logic              reset,
  input  logic              commit_valid,
  output logic              commit_ready,
  input  logic [31:0]       commit_pc,
  input  logic [31:0]       commit_inst,
  input  logic              commit_we,
  input  logic [4:0]        commit_waddr,
  input  logic [31:0]       commit_wdata,
  output logic [ADDR_W-1:0] exp_addr,
  input  logic [101:0]      exp_data,
  output logic [ADDR_W-1:0] rec_index,
  output logic              done,
  output logic              fail,
  output logic [2:0]        fail_code,
  output logic [ADDR_W-1:0] fail_index
);

  typedef enum logic [2:0] {StFetch, StWait, StReady, StDone, StFail} state_e;

  localparam logic [2:0] CodeOverrun = 3'd6;
  localparam logic [2:0] CodeTimeout = 3'd7;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   rec_q, rec_d;
  logic [101:0]        exp_q, exp_d;
  logic [TO_W-1:0]     ctr_q, ctr_d;
  logic [2:0]          code_q, code_d;
  logic [ADDR_W-1:0]   findex_q, findex_d;

  logic [31:0]         exp_pc, exp_inst, exp_wdata;
  logic                exp_we;
  logic [4:0]          exp_waddr;
  logic                eff_we;
  logic                xfer;
  logic [2:0]          cmp_code;
  logic [ADDR_W:0]     rec_inc;
  logic                last_rec;
  logic [TO_W-1:0]     ctr_inc;

  assign exp_pc    = exp_q[101:70];
  assign exp_inst  = exp_q[69:38];
  assign exp_we    = exp_q[37];
  assign exp_waddr = exp_q[36:32];
  assign exp_wdata = exp_q[31:0];

  // A write to $0 has no architectural effect, so it counts as no write.
  assign eff_we = commit_we & (commit_waddr != 5'd0);
  assign xfer   = commit_valid & commit_ready;

  // One extra bit so a full 2**ADDR_W run can be detected without wrapping rec_index.
  assign rec_inc  = {1'b0, rec_q} + 1'b1;
  assign last_rec = (rec_inc == (ADDR_W + 1)'(NUM_RECORDS));
  assign ctr_inc  = ctr_q + 1'b1;

  always_comb begin
    cmp_code = 3'd0;
    if (commit_pc != exp_pc) begin
      cmp_code = 3'd1;
    end else if (commit_inst != exp_inst) begin
      cmp_code = 3'd2;
    end else if (eff_we != exp_we) begin
      cmp_code = 3'd3;
    end else if (exp_we && (commit_waddr != exp_waddr)) begin
      cmp_code = 3'd4;
    end else if (exp_we && (commit_wdata != exp_wdata)) begin
      cmp_code = 3'd5;
    end
  end

  always_comb begin
    state_d  = state_q;
    rec_d    = rec_q;
    exp_d    = exp_q;
    ctr_d    = ctr_q;
    code_d   = code_q;
    findex_d = findex_q;
    case (state_q)
      StFetch: begin
        ctr_d   = '0;
        state_d = StWait;
      end
      StWait: begin
        exp_d   = exp_data;
        state_d = StReady;
      end
      StReady: begin
        if (xfer) begin
          ctr_d = '0;
          if (cmp_code == 3'd0) begin
            if (!rec_inc[ADDR_W]) begin
              rec_d = rec_inc[ADDR_W-1:0];
            end
            state_d = last_rec ? StDone : StFetch;
          end else begin
            state_d  = StFail;
            code_d   = cmp_code;
            findex_d = rec_q;
          end
        end else if (TIMEOUT != 0) begin
          ctr_d = ctr_inc;
          if (ctr_inc == TO_W'(TIMEOUT)) begin
            state_d  = StFail;
            code_d   = CodeTimeout;
            findex_d = rec_q;
          end
        end
      end
      StDone: begin
        if (xfer) begin
          state_d  = StFail;
          code_d   = CodeOverrun;
          findex_d = rec_q;
        end
      end
      StFail: begin
      end
      default: state_d = StFetch;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      state_q  <= StFetch;
      rec_q    <= '0;
      exp_q    <= '0;
      ctr_q    <= '0;
      code_q   <= '0;
      findex_q <= '0;
    end else begin
      state_q  <= state_d;
      rec_q    <= rec_d;
      exp_q    <= exp_d;
      ctr_q    <= ctr_d;
      code_q   <= code_d;
      findex_q <= findex_d;
    end
  end

  assign commit_ready = (state_q == StReady) || (state_q == StDone) || (state_q == StFail);
  assign done         = (state_q == StDone);
  assign fail         = (state_q == StFail);
  assign exp_addr     = rec_q;
  assign rec_index    = rec_q;
  assign fail_code    = code_q;
  assign fail_index   = findex_q;

endmodule

// File: tb/tb_trace_checker.sv
// Randomized scoreboard bench for trace_checker: a record-level reference model predicts the
// status after every accepted commit or explicit probe; a monitor compares when each occurs.
module tb_trace_checker;
  localparam int unsigned AW     = 3;
  localparam int unsigned NREC   = 8;
  localparam int unsigned TMO    = 16;
  localparam int unsigned TOW    = 8;
  localparam int unsigned MAXIDX = (1 << AW) - 1;

  logic          clk_in = 1'b0;
  logic          reset = 1'b1;
  logic          commit_valid = 1'b0;
  logic          commit_ready;
  logic [31:0]   commit_pc = '0, commit_inst = '0, commit_wdata = '0;
  logic          commit_we = 1'b0;
  logic [4:0]    commit_waddr = '0;
  logic [AW-1:0] exp_addr, rec_index, fail_index;
  logic [101:0]  exp_data;
  logic          done, fail;
  logic [2:0]    fail_code;

  always #5 clk_in = ~clk_in;

  trace_checker #(.ADDR_W(AW), .NUM_RECORDS(NREC), .TIMEOUT(TMO), .TO_W(TOW)) dut (
    .clk_in(clk_in), .reset(reset), .commit_valid(commit_valid), .commit_ready(commit_ready),
    .commit_pc(commit_pc), .commit_inst(commit_inst), .commit_we(commit_we),
    .commit_waddr(commit_waddr), .commit_wdata(commit_wdata), .exp_addr(exp_addr),
    .exp_data(exp_data), .rec_index(rec_index), .done(done), .fail(fail),
    .fail_code(fail_code), .fail_index(fail_index)
  );

  // Expected-trace ROM with one cycle of read latency.
  logic [101:0] rom [NREC];
  always @(posedge clk_in) exp_data <= rom[exp_addr];

  typedef struct packed {
    logic          ready;
    logic          done;
    logic          fail;
    logic [2:0]    code;
    logic [AW-1:0] index;
    logic [AW-1:0] rec;
  } status_t;

  status_t exp_q[$];
  int      checks = 0;
  int      errors = 0;
  logic    probe_req = 1'b0;

  // Reference model: 0 running, 1 done, 2 failed.
  int m_count, m_state, m_code, m_index;

  function automatic int rec_disp();
    return (m_count > int'(MAXIDX)) ? int'(MAXIDX) : m_count;
  endfunction

  function automatic status_t m_status(input logic rdy);
    status_t s;
    s.ready = rdy;
    s.done  = (m_state == 1);
    s.fail  = (m_state == 2);
    s.code  = 3'(m_code);
    s.index = AW'(m_index);
    s.rec   = AW'(rec_disp());
    return s;
  endfunction

  function automatic int ref_code(input logic [101:0] r, input logic [31:0] pc, inst,
                                  input logic we, input logic [4:0] wa, input logic [31:0] wd);
    logic eff;
    eff = we && (wa != 0);
    if (pc != r[101:70]) return 1;
    if (inst != r[69:38]) return 2;
    if (eff != r[37]) return 3;
    if (r[37] && wa != r[36:32]) return 4;
    if (r[37] && wd != r[31:0]) return 5;
    return 0;
  endfunction

  // Monitor: compares after every accepted commit and every probe request.
  always @(posedge clk_in) begin
    logic    xfer, prb;
    status_t a, e;
    xfer = commit_valid & commit_ready & ~reset;
    prb  = probe_req;
    #1;
    if (xfer || prb) begin
      a = {commit_ready, done, fail, fail_code, fail_index, rec_index};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_response: actual %h, required nothing", a);
      end else begin
        e = exp_q.pop_front();
        if (a !== e) begin
          errors++;
          $display("FAIL status @%0t: actual rdy=%b done=%b fail=%b code=%0d idx=%0d rec=%0d, required rdy=%b done=%b fail=%b code=%0d idx=%0d rec=%0d",
                   $time, a.ready, a.done, a.fail, a.code, a.index, a.rec,
                   e.ready, e.done, e.fail, e.code, e.index, e.rec);
        end
      end
    end
  end

  task automatic fill_rom();
    logic [31:0] pc, inst, wd;
    logic        we;
    logic [4:0]  wa;
    for (int i = 0; i < int'(NREC); i++) begin
      pc   = 32'h0040_0000 + 32'(i * 4);
      inst = $urandom;
      wd   = $urandom;
      we   = 1'($urandom);
      wa   = 5'($urandom_range(1, 31));
      rom[i] = {pc, inst, we, wa, wd};
    end
  endtask

  task automatic do_reset();
    @(negedge clk_in);
    reset = 1'b1;
    commit_valid = 1'b0;
    m_count = 0; m_state = 0; m_code = 0; m_index = 0;
    exp_q.push_back(m_status(1'b0));
    probe_req = 1'b1;
    @(negedge clk_in);
    reset = 1'b0;
    probe_req = 1'b0;
  endtask

  task automatic probe(input logic rdy);
    exp_q.push_back(m_status(rdy));
    probe_req = 1'b1;
    @(negedge clk_in);
    probe_req = 1'b0;
  endtask

  task automatic wait_ready(output logic ok);
    int n;
    n = 0;
    while (!commit_ready && n < 20) begin
      @(negedge clk_in);
      n++;
    end
    ok = commit_ready;
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL ready_wait: actual commit_ready=0 after %0d cycles, required 1", n);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      commit_pc = $urandom; commit_inst = $urandom; commit_wdata = $urandom;
      commit_we = 1'($urandom); commit_waddr = 5'($urandom);
      @(negedge clk_in);
    end
  endtask

  // Called at a negedge; holds valid until accepted, then predicts the outcome.
  task automatic send(input logic [31:0] pc, inst, input logic we, input logic [4:0] wa,
                      input logic [31:0] wd);
    logic ok;
    int   c;
    commit_pc = pc; commit_inst = inst; commit_we = we; commit_waddr = wa; commit_wdata = wd;
    commit_valid = 1'b1;
    wait_ready(ok);
    if (!ok) begin
      commit_valid = 1'b0;
      return;
    end
    if (m_state == 0) begin
      c = ref_code(rom[m_count], pc, inst, we, wa, wd);
      if (c == 0) begin
        m_count++;
        if (m_count == int'(NREC)) m_state = 1;
      end else begin
        m_state = 2; m_code = c; m_index = rec_disp();
      end
    end else if (m_state == 1) begin
      m_state = 2; m_code = 6; m_index = rec_disp();
    end
    exp_q.push_back(m_status(m_state != 0));
    @(negedge clk_in);
    commit_valid = 1'b0;
  endtask

  // Builds the commit a correct CPU would make for record i, then corrupts fields per mut.
  task automatic send_rec(input int i, input int mut);
    logic [101:0] r;
    logic [31:0]  pc, inst, wd;
    logic         we;
    logic [4:0]   wa;
    r = rom[i];
    pc = r[101:70]; inst = r[69:38]; wd = r[31:0];
    if (r[37]) begin
      we = 1'b1; wa = r[36:32];
    end else begin
      wd = $urandom;
      if ($urandom_range(0, 1) == 1) begin we = 1'b1; wa = 5'd0; end
      else begin we = 1'b0; wa = 5'($urandom); end
    end
    if (mut[0]) pc ^= 32'd1 << $urandom_range(0, 31);
    if (mut[1]) inst ^= 32'd1 << $urandom_range(0, 31);
    if (mut[2]) begin
      if (r[37]) we = 1'b0;
      else begin we = 1'b1; wa = 5'($urandom_range(1, 31)); end
    end
    if (mut[3]) wa ^= 5'd1 << $urandom_range(0, 4);
    if (mut[4]) wd ^= 32'd1 << $urandom_range(0, 31);
    send(pc, inst, we, wa, wd);
  endtask

  initial begin
    logic ok;
    int   k;

    // Full clean run ending in DONE with rec_index saturated, then overrun.
    fill_rom();
    do_reset();
    for (int i = 0; i < int'(NREC); i++) begin
      send_rec(i, 0);
      idle($urandom_range(0, 3));
    end
    probe(1'b1);
    send_rec(0, 0);
    send_rec(1, 0);
    probe(1'b1);

    // Record 2 expects wdata 5, CPU writes 6.
    fill_rom();
    rom[2][37] = 1'b1; rom[2][36:32] = 5'd3; rom[2][31:0] = 32'h0000_0005;
    do_reset();
    send_rec(0, 0);
    send_rec(1, 0);
    send(rom[2][101:70], rom[2][69:38], 1'b1, 5'd3, 32'h0000_0006);
    send_rec(3, 0);

    // Wrong pc and inst together: pc cause wins.
    fill_rom();
    do_reset();
    send_rec(0, 0);
    send(32'h0040_0008, ~rom[1][69:38], rom[1][37], rom[1][36:32], rom[1][31:0]);

    // Write to $0 against no-write record matches; no-write commit against a $0 write record.
    fill_rom();
    rom[0][37] = 1'b0;
    rom[1][37] = 1'b1; rom[1][36:32] = 5'd0;
    do_reset();
    send(rom[0][101:70], rom[0][69:38], 1'b1, 5'd0, 32'hdead_beef);
    send(rom[1][101:70], rom[1][69:38], 1'b1, 5'd0, rom[1][31:0]);

    // Random single/multiple-field faults at a random record.
    for (int t = 0; t < 25; t++) begin
      fill_rom();
      do_reset();
      k = $urandom_range(0, NREC - 1);
      for (int i = 0; i < k; i++) begin
        send_rec(i, 0);
        idle($urandom_range(0, 2));
      end
      send_rec(k, $urandom_range(1, 31));
      idle($urandom_range(0, 2));
      send_rec((m_count < int'(NREC)) ? m_count : 0, 0);
    end

    // Reset mid-run restarts from record 0.
    fill_rom();
    do_reset();
    for (int i = 0; i < 3; i++) send_rec(i, 0);
    do_reset();
    for (int i = 0; i < int'(NREC); i++) send_rec(i, 0);
    probe(1'b1);

    // Timeout after TMO idle READY cycles.
    fill_rom();
    do_reset();
    send_rec(0, 0);
    send_rec(1, 0);
    wait_ready(ok);
    if (ok) begin
      repeat (TMO - 2) @(negedge clk_in);
      probe(1'b1);
      m_state = 2; m_code = 7; m_index = rec_disp();
      probe(1'b1);
    end
    do_reset();

    idle(3);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: actual %0d pending, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
